// File: rtl/key_sched_dec.sv
// AES-128 decryption-side round-key scheduler: expands forward to round key 10,
// then walks back through round keys 10..0 on request using the inverse recurrence.

module sub_bytes (
   input  logic       mode,
   input  logic [7:0] din,
   output logic [7:0] dout
);

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] t;
      p = '0;
      t = a;
      for (int unsigned i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ t;
         t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Multiplicative inverse as x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0.
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] sq;
      logic [7:0] r;
      sq = x;
      r  = 8'h01;
      for (int unsigned i = 1; i < 8; i++) begin
         sq = gf_mul(sq, sq);
         r  = gf_mul(r, sq);
      end
      return r;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] v, input int unsigned n);
      return (v << n) | (v >> (8 - n));
   endfunction

   function automatic logic [7:0] aff(input logic [7:0] x);
      return x ^ rotl(x, 1) ^ rotl(x, 2) ^ rotl(x, 3) ^ rotl(x, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_aff(input logic [7:0] x);
      return rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05;
   endfunction

   always_comb begin
      dout = mode ? gf_inv(inv_aff(din)) : aff(gf_inv(din));
   end

endmodule

module key_sched_dec (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         key_load,
   input  logic [127:0] key,
   input  logic         step,
   input  logic         rewind,
   output logic         busy,
   output logic         rk_valid,
   output logic [3:0]   rk_round,
   output logic [127:0] rk_data
);

   typedef enum logic [1:0] {IDLE, EXPAND, HOLD} state_t;

   state_t       st, st_n;
   logic [127:0] wk, wk_n;
   logic [127:0] last_rk, last_rk_n;
   logic [3:0]   cnt, cnt_n;

   logic [31:0]  w0, w1, w2, w3;
   logic [31:0]  sub_x, sb, t_word, r_word;
   logic [3:0]   rc_idx;
   logic [127:0] fwd, rev;

   function automatic logic [7:0] rcon(input logic [3:0] i);
      case (i)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   assign {w0, w1, w2, w3} = wk;

   // One S-box bank serves both directions: reverse recovers old w3 as w3^w2.
   assign sub_x  = (st == EXPAND) ? w3 : (w3 ^ w2);
   assign rc_idx = (st == EXPAND) ? (cnt + 4'd1) : cnt;

   for (genvar g = 0; g < 4; g++) begin : g_sb
      sub_bytes u_sb (
         .mode (1'b0),
         .din  (sub_x[8*g +: 8]),
         .dout (sb[8*g +: 8])
      );
   end

   assign t_word = {sb[23:16], sb[15:8], sb[7:0], sb[31:24]};
   assign r_word = {rcon(rc_idx), 24'h0};

   always_comb begin
      logic [31:0] f0, f1, f2, f3;
      f0  = w0 ^ t_word ^ r_word;
      f1  = w1 ^ f0;
      f2  = w2 ^ f1;
      f3  = w3 ^ f2;
      fwd = {f0, f1, f2, f3};
      rev = {w0 ^ t_word ^ r_word, w1 ^ w0, w2 ^ w1, w3 ^ w2};
   end

   always_comb begin
      st_n      = st;
      wk_n      = wk;
      cnt_n     = cnt;
      last_rk_n = last_rk;
      busy      = (st == EXPAND);
      rk_valid  = (st == HOLD);
      if (key_load) begin
         st_n  = EXPAND;
         wk_n  = key;
         cnt_n = '0;
      end else begin
         case (st)
            EXPAND: begin
               wk_n  = fwd;
               cnt_n = cnt + 4'd1;
               if (cnt == 4'd9) begin
                  last_rk_n = fwd;
                  st_n      = HOLD;
               end
            end
            HOLD: begin
               if (rewind) begin
                  wk_n  = last_rk;
                  cnt_n = 4'd10;
               end else if (step && (cnt != 4'd0)) begin
                  wk_n  = rev;
                  cnt_n = cnt - 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st      <= IDLE;
         wk      <= '0;
         last_rk <= '0;
         cnt     <= '0;
      end else begin
         st      <= st_n;
         wk      <= wk_n;
         last_rk <= last_rk_n;
         cnt     <= cnt_n;
      end
   end

   assign rk_round = cnt;
   assign rk_data  = wk;

endmodule
